sha256_padder: RTL
==================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: in_data  input  8  message byte; first byte lands in bits 511:504 of a block.
REQ-004 SHALL have port: in_valid  input  1  in_data/in_last/in_empty qualified.
REQ-005 SHALL have port: in_last  input  1  current beat ends the message.
REQ-006 SHALL have port: in_empty  input  1  with in_valid&in_last: zero-length message, in_data ignored.
REQ-007 SHALL have port: in_ready  output  1  byte accepted when in_valid&in_ready.
REQ-008 SHALL have port: blk_data  output  512  padded block, byte 0 at bits 511:504.
REQ-009 SHALL have port: blk_valid  output  1  blk_data/blk_last valid.
REQ-010 SHALL have port: blk_last  output  1  block is final block of message.
REQ-011 SHALL have port: blk_ready  input  1  block consumed when blk_valid&blk_ready.

Function
REQ-012 SHALL implement FSM states FILL, EMIT, PAD; in_ready=1 only in FILL; blk_valid=1 only in EMIT and PAD.
REQ-013 FILL: accepted byte SHALL be written at byte pointer ptr (0..63), ptr incremented, 64-bit bit-length counter += 8 (wraps mod 2^64).
REQ-014 FILL, ptr==63 accepted without in_last SHALL go EMIT with blk_last=0; ptr->0.
REQ-015 On accepted in_last, let r = bytes of message in current block (0 for in_empty, else ptr+1); SHALL compute block registered, blk_valid asserted the following cycle (latency 1).
REQ-016 r<=55: byte r=0x80, bytes r+1..55 zero, bytes 56..63 = bit length big-endian; EMIT, blk_last=1.
REQ-017 56<=r<=63: byte r=0x80, remaining bytes zero; EMIT blk_last=0, then PAD block (bytes 0..55 zero, 56..63 length), blk_last=1.
REQ-018 r==64: full data block EMIT blk_last=0, then PAD block (byte 0=0x80, bytes 1..55 zero, 56..63 length), blk_last=1.
REQ-019 blk_data/blk_last SHALL be stable while blk_valid&!blk_ready; state advances only on handshake.
REQ-020 On handshake of non-last block SHALL go to FILL or PAD per REQ-017/018 with buffer cleared to zero.
REQ-021 On handshake of last block SHALL go FILL with ptr=0, length counter=0, buffer zeroed; in_ready=1 next cycle.
REQ-022 Unused buffer bytes SHALL read zero in every emitted block.
REQ-023 Block throughput: ≥1 block per 65 cycles with blk_ready held high.

Reset
REQ-024 reset_n low SHALL immediately force: FILL, ptr=0, length=0, buffer=0, blk_valid=0, blk_last=0, blk_data=0, in_ready=0.
REQ-025 in_ready SHALL rise the first clk edge after reset_n deasserts.
REQ-026 Reset mid-message or mid-handshake SHALL discard all partial state; no block emitted for the aborted message.

Configuration
REQ-027 Macro SHA256_PAD_BLKCNT_EN defined: SHALL add output blk_cnt (16 bits), reset 0, incremented on each block handshake, cleared to 0 on last-block handshake (wraps at 2^16).
REQ-028 Macro undefined: blk_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 "abc" (0x61,0x62,0x63, last on 0x63) -> one block 0x6162638000...0018, blk_last=1, valid one cycle after last byte.
REQ-030 in_empty&in_last -> one block 0x8000...0000 (length 0), blk_last=1.
REQ-031 56 bytes 0x00 -> block1 byte56=0x80 rest zero, blk_last=0; block2 zeros with length 0x1C0, blk_last=1.
REQ-032 64 bytes 0xFF -> block1 all 0xFF, blk_last=0; block2 byte0=0x80, length 0x200, blk_last=1.
REQ-033 blk_ready low 10 cycles during "abc" emit -> blk_data stable, in_ready=0; with SHA256_PAD_BLKCNT_EN, blk_cnt 0->0 after last.
REQ-034 reset_n pulsed low after 30 bytes, then "abc" -> only the "abc" block of REQ-029 emitted.

Source files
------------

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder: byte stream in, 512-bit padded blocks out
// Optional block counter output enabled by defining SHA256_PAD_BLKCNT_EN.
module sha256_padder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
    input  logic         blk_ready
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);
    typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;

    state_t         state_q, state_d;
    logic [5:0]     ptr_q, ptr_d;
    logic [63:0]    len_q, len_d;
    logic [511:0]   buf_q, buf_d;
    logic           last_q, last_d;
    logic           pad_next_q, pad_next_d;
    logic           pad80_q, pad80_d;
    logic           in_ready_q, in_ready_d;
    logic           blk_valid_q, blk_valid_d;

    logic           accept;
    logic           hs;
    logic [6:0]     r;
    logic [63:0]    len_new;
    logic [511:0]   wbuf;
    logic [8:0]     wr_pos;
    logic [8:0]     pad_pos;

    assign accept = in_valid & in_ready_q & (state_q == FILL);
    assign hs     = blk_valid_q & blk_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        buf_d      = buf_q;
        last_d     = last_q;
        pad_next_d = pad_next_q;
        pad80_d    = pad80_q;
        wbuf       = buf_q;
        len_new    = len_q;
        r          = {1'b0, ptr_q};
        wr_pos     = 9'd511 - {ptr_q, 3'b000};
        pad_pos    = 9'd511;
        case (state_q)
            FILL: begin
                if (accept) begin
                    // in_empty closes the message at the current pointer without storing a byte
                    if (!(in_last && in_empty)) begin
                        wbuf[wr_pos -: 8] = in_data;
                        len_new           = len_q + 64'd8;
                        r                 = {1'b0, ptr_q} + 7'd1;
                    end
                    len_d = len_new;
                    ptr_d = ptr_q + 6'd1;
                    if (in_last) begin
                        ptr_d   = 6'd0;
                        state_d = EMIT;
                        pad_pos = 9'd511 - {r[5:0], 3'b000};
                        if (!r[6]) begin
                            wbuf[pad_pos -: 8] = 8'h80;
                        end
                        if (r <= 7'd55) begin
                            wbuf[63:0] = len_new;
                            last_d     = 1'b1;
                            pad_next_d = 1'b0;
                        end else begin
                            last_d     = 1'b0;
                            pad_next_d = 1'b1;
                            pad80_d    = r[6];
                        end
                    end else if (ptr_q == 6'd63) begin
                        state_d    = EMIT;
                        last_d     = 1'b0;
                        pad_next_d = 1'b0;
                    end
                    buf_d = wbuf;
                end
            end
            EMIT, PAD: begin
                if (hs) begin
                    pad80_d    = 1'b0;
                    pad_next_d = 1'b0;
                    if (last_q) begin
                        state_d = FILL;
                        ptr_d   = 6'd0;
                        len_d   = 64'd0;
                        buf_d   = '0;
                        last_d  = 1'b0;
                    end else if (pad_next_q) begin
                        state_d = PAD;
                        buf_d   = {(pad80_q ? 8'h80 : 8'h00), 440'd0, len_q};
                        last_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                        buf_d   = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
        in_ready_d  = (state_d == FILL);
        blk_valid_d = (state_d != FILL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            ptr_q       <= 6'd0;
            len_q       <= 64'd0;
            buf_q       <= '0;
            last_q      <= 1'b0;
            pad_next_q  <= 1'b0;
            pad80_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            buf_q       <= buf_d;
            last_q      <= last_d;
            pad_next_q  <= pad_next_d;
            pad80_q     <= pad80_d;
            in_ready_q  <= in_ready_d;
            blk_valid_q <= blk_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_data  = buf_q;
    assign blk_valid = blk_valid_q;
    assign blk_last  = last_q;

`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (hs) begin
            blk_cnt_d = last_q ? 16'd0 : blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt_q <= 16'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif
endmodule
